// File: rtl/regw_arbiter.sv
// Round-robin arbiter sharing the register file write port between
// the EX result path (req0) and the MEM/load result path (req1).
module regw_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              write,
  output logic [ADDR_W-1:0] regw_addr,
  output logic [DATA_W-1:0] regw_data,
  output logic              last_grant,
  output logic [7:0]        conflict_cnt
);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_t;

  logic              write_q, write_d;
  wb_t               wb_q, wb_d;
  logic              lg_q, lg_d;
  logic [7:0]        cnt_q, cnt_d;

  logic              both;
  logic              same_addr;
  logic              gnt0, gnt1;
  logic              xfer;
  wb_t               win;

  assign both = req0_valid & req1_valid;

  // x0 is never a real hazard, so it never forces load-first ordering
  assign same_addr = both
                   & (req0_addr == req1_addr)
                   & (|req0_addr);

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    unique case ({req1_valid, req0_valid})
      2'b01: gnt0 = 1'b1;
      2'b10: gnt1 = 1'b1;
      2'b11: begin
        if (same_addr || !lg_q) gnt1 = 1'b1;
        else                    gnt0 = 1'b1;
      end
      default: ;
    endcase
  end

  assign req0_ready = gnt0 & ~reset;
  assign req1_ready = gnt1 & ~reset;
  assign xfer       = req0_ready | req1_ready;

  always_comb begin
    win = '0;
    unique case (1'b1)
      gnt1:    win = '{addr: req1_addr, data: req1_data};
      gnt0:    win = '{addr: req0_addr, data: req0_data};
      default: win = '0;
    endcase
  end

  always_comb begin
    write_d = xfer & (|win.addr);
    wb_d    = write_d ? win : wb_q;
    lg_d    = xfer ? gnt1 : lg_q;
    cnt_d   = cnt_q;
    if (both && cnt_q != 8'hff)
      cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      write_q <= 1'b0;
      wb_q    <= '0;
      lg_q    <= 1'b1;
      cnt_q   <= 8'd0;
    end else begin
      write_q <= write_d;
      wb_q    <= wb_d;
      lg_q    <= lg_d;
      cnt_q   <= cnt_d;
    end
  end

  assign write        = write_q;
  assign regw_addr    = wb_q.addr;
  assign regw_data    = wb_q.data;
  assign last_grant   = lg_q;
  assign conflict_cnt = cnt_q;

  a_onehot: assert property (
    @(posedge clock) disable iff (reset)
    !(req0_ready && req1_ready));

  a_rdy_valid: assert property (
    @(posedge clock) disable iff (reset)
    (!req0_ready || req0_valid) && (!req1_ready || req1_valid));

endmodule

// File: tb/tb_regw_arbiter.sv
// Bench for regw_arbiter: directed scenarios plus random traffic
// compared each cycle against a rule-level model.
module tb_regw_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req0_valid = 1'b0;
  logic [4:0]  req0_addr = '0;
  logic [31:0] req0_data = '0;
  logic        req0_ready;
  logic        req1_valid = 1'b0;
  logic [4:0]  req1_addr = '0;
  logic [31:0] req1_data = '0;
  logic        req1_ready;
  logic        write;
  logic [4:0]  regw_addr;
  logic [31:0] regw_data;
  logic        last_grant;
  logic [7:0]  conflict_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  regw_arbiter #(.ADDR_W(5), .DATA_W(32)) dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_addr(req0_addr),
    .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr),
    .req1_data(req1_data), .req1_ready(req1_ready),
    .write(write), .regw_addr(regw_addr), .regw_data(regw_data),
    .last_grant(last_grant), .conflict_cnt(conflict_cnt)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Which requester wins, straight from the grant rules (-1 = none)
  function automatic int pick(input bit v0, input bit v1,
                              input logic [4:0] a0,
                              input logic [4:0] a1, input bit lg);
    if (!v0 && !v1) return -1;
    if (v0 && !v1)  return 0;
    if (!v0 && v1)  return 1;
    if (a0 == a1 && a0 != 0) return 1;
    return lg ? 0 : 1;
  endfunction

  bit          m_write = 1'b0;
  logic [4:0]  m_addr  = '0;
  logic [31:0] m_data  = '0;
  bit          m_known = 1'b1;
  bit          m_lg    = 1'b1;
  int          m_cnt   = 0;
  int          m_g     = -1;

  always @(posedge clock or posedge reset) begin
    int g;
    if (reset) begin
      m_write <= 1'b0;
      m_addr  <= '0;
      m_data  <= '0;
      m_known <= 1'b1;
      m_lg    <= 1'b1;
      m_cnt   <= 0;
      m_g     <= -1;
    end else begin
      g = pick(req0_valid, req1_valid, req0_addr, req1_addr, m_lg);
      m_g <= g;
      m_write <= 1'b0;
      if (g >= 0) begin
        m_lg <= (g == 1);
        if ((g == 1 ? req1_addr : req0_addr) != 0) begin
          m_write <= 1'b1;
          m_addr  <= (g == 1) ? req1_addr : req0_addr;
          m_data  <= (g == 1) ? req1_data : req0_data;
          m_known <= 1'b1;
        end else begin
          m_known <= 1'b0;
        end
      end
      if (req0_valid && req1_valid && m_cnt < 255)
        m_cnt <= m_cnt + 1;
    end
  end

  always @(negedge clock) begin
    int e;
    if (chk_en) begin
      e = pick(req0_valid, req1_valid, req0_addr, req1_addr, m_lg);
      chk("ready0", 32'(req0_ready), 32'(!reset && e == 0));
      chk("ready1", 32'(req1_ready), 32'(!reset && e == 1));
      chk("write", 32'(write), 32'(m_write));
      chk("last_grant", 32'(last_grant), 32'(m_lg));
      chk("conflict_cnt", 32'(conflict_cnt), 32'(m_cnt));
      if (m_known) begin
        chk("regw_addr", 32'(regw_addr), 32'(m_addr));
        chk("regw_data", regw_data, m_data);
      end
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic mid();
    @(negedge clock);
  endtask

  initial begin
    cyc();
    chk_en = 1'b1;
    req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'hDEADBEEF;
    mid();
    chk("rst_write", 32'(write), 32'd0);
    chk("rst_lg", 32'(last_grant), 32'd1);
    chk("rst_cnt", 32'(conflict_cnt), 32'd0);
    chk("rst_rdy0", 32'(req0_ready), 32'd0);
    #2 reset = 1'b0;
    #1 chk("t1_rdy0", 32'(req0_ready), 32'd1);
    cyc();
    req0_valid = 1'b0;
    mid();
    chk("t1_write", 32'(write), 32'd1);
    chk("t1_addr", 32'(regw_addr), 32'd5);
    chk("t1_data", regw_data, 32'hDEADBEEF);
    chk("t1_lg", 32'(last_grant), 32'd0);

    cyc();
    req1_valid = 1'b1; req1_addr = 5'd9; req1_data = 32'h99;
    cyc();
    req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'h33;
    req1_valid = 1'b1; req1_addr = 5'd4; req1_data = 32'h44;
    for (int k = 0; k < 4; k++) begin
      mid();
      chk("t2_rdy0", 32'(req0_ready), 32'(k % 2 == 0));
      chk("t2_rdy1", 32'(req1_ready), 32'(k % 2 == 1));
      cyc();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    mid();
    chk("t2_cnt", 32'(conflict_cnt), 32'd4);
    chk("t2_write", 32'(write), 32'd1);
    chk("t2_addr", 32'(regw_addr), 32'd4);

    cyc();
    req0_valid = 1'b1; req0_addr = 5'd7; req0_data = 32'h11;
    req1_valid = 1'b1; req1_addr = 5'd7; req1_data = 32'h22;
    mid();
    chk("t3_rdy1", 32'(req1_ready), 32'd1);
    chk("t3_rdy0", 32'(req0_ready), 32'd0);
    cyc();
    req1_valid = 1'b0;
    mid();
    chk("t3_w1", 32'(write), 32'd1);
    chk("t3_d1", regw_data, 32'h22);
    chk("t3_rdy0b", 32'(req0_ready), 32'd1);
    cyc();
    req0_valid = 1'b0;
    mid();
    chk("t3_w2", 32'(write), 32'd1);
    chk("t3_a2", 32'(regw_addr), 32'd7);
    chk("t3_d2", regw_data, 32'h11);

    cyc();
    req1_valid = 1'b1; req1_addr = 5'd0; req1_data = 32'hFF;
    mid();
    chk("t4_rdy1", 32'(req1_ready), 32'd1);
    cyc();
    req1_valid = 1'b0;
    mid();
    chk("t4_write", 32'(write), 32'd0);
    chk("t4_lg", 32'(last_grant), 32'd1);

    for (int i = 0; i < 500; i++) begin
      cyc();
      if (!(req0_valid && m_g != 0)) begin
        req0_valid = ($urandom_range(0, 3) != 0);
        req0_addr  = 5'($urandom_range(0, 3));
        req0_data  = $urandom;
      end
      if (!(req1_valid && m_g != 1)) begin
        req1_valid = ($urandom_range(0, 3) != 0);
        req1_addr  = 5'($urandom_range(0, 3));
        req1_data  = $urandom;
      end
    end
    cyc();
    req0_valid = 1'b0; req1_valid = 1'b0;

    mid();
    #2 reset = 1'b1;
    #2 reset = 1'b0;
    cyc();
    req0_valid = 1'b1; req0_addr = 5'd1; req0_data = 32'hA1;
    req1_valid = 1'b1; req1_addr = 5'd2; req1_data = 32'hB2;
    repeat (300) cyc();
    mid();
    chk("sat_cnt", 32'(conflict_cnt), 32'd255);
    repeat (3) cyc();
    mid();
    chk("sat_hold", 32'(conflict_cnt), 32'd255);

    cyc();
    chk("ar_pre_write", 32'(write), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("ar_write", 32'(write), 32'd0);
    chk("ar_rdy0", 32'(req0_ready), 32'd0);
    chk("ar_rdy1", 32'(req1_ready), 32'd0);
    chk("ar_cnt", 32'(conflict_cnt), 32'd0);
    mid();
    #1 reset = 1'b0;
    #1;
    chk("ar_rdy0_after", 32'(req0_ready), 32'd1);
    chk("ar_rdy1_after", 32'(req1_ready), 32'd0);
    cyc();
    req0_valid = 1'b0; req1_valid = 1'b0;
    mid();
    chk("ar_lg", 32'(last_grant), 32'd0);
    chk("ar_waddr", 32'(regw_addr), 32'd1);
    repeat (2) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
